// File: rtl/bcd_display_scan_3_pkg.sv
// Shared types and constants for the 3-digit BCD display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package bcd_display_scan_3_pkg;

  typedef enum logic [1:0] {
    S_D0 = 2'd0,
    S_D1 = 2'd1,
    S_D2 = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] AN_OFF = 3'b111;

  function automatic state_t next_slot(input state_t s);
    unique case (s)
      S_D0:    next_slot = S_D1;
      S_D1:    next_slot = S_D2;
      default: next_slot = S_D0;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_scan_3_bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern.
// Codes 10..15 render as a dash.
module bcd_to_seg7
  import bcd_display_scan_3_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan_3.sv
// Multiplexed 3-digit common-anode display scanner with
// inter-slot blanking, leading-zero blanking and blink.
module bcd_display_scan_3
  import bcd_display_scan_3_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK        = 500,
  parameter int BLINK_FRAMES = 128,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       enable,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       maxed,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CLAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CBLANK = CW'(BLANK);
  localparam logic [FW-1:0] FLAST  = FW'(BLINK_FRAMES - 1);

  state_t        state, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] fcnt, fc_n;
  logic          phase, ph_n;
  logic [3:0]    s0, s1, s2;
  logic [3:0]    s0_n, s1_n, s2_n;
  logic [2:0]    an_n;
  logic [6:0]    seg_n;
  logic [6:0]    seg_dec;
  logic [3:0]    dig;
  logic          wrap;
  logic          lit;
  logic          blank1, blank2;

  always_comb begin
    st_n  = state;
    cnt_n = cnt;
    fc_n  = fcnt;
    ph_n  = phase;
    s0_n  = s0;
    s1_n  = s1;
    s2_n  = s2;
    wrap  = (cnt == CLAST);
    if (enable) begin
      cnt_n = wrap ? '0 : cnt + CW'(1);
      if (wrap)
        st_n = next_slot(state);
      if (state == S_D0 && cnt == '0) begin
        s0_n = d0;
        s1_n = d1;
        s2_n = d2;
      end
      // Blink timing only runs while maxed; otherwise stay lit.
      if (!maxed) begin
        fc_n = '0;
        ph_n = 1'b1;
      end else if (wrap && state == S_D2) begin
        if (fcnt == FLAST) begin
          fc_n = '0;
          ph_n = ~phase;
        end else begin
          fc_n = fcnt + FW'(1);
        end
      end
    end
  end

  always_comb begin
    blank2 = LZB && (s2_n == 4'd0);
    blank1 = blank2 && (s1_n == 4'd0);
    lit    = enable && ph_n && (cnt_n >= CBLANK);
    an_n   = AN_OFF;
    dig    = s0_n;
    unique case (st_n)
      S_D1: begin
        dig = s1_n;
        if (lit && !blank1)
          an_n = 3'b101;
      end
      S_D2: begin
        dig = s2_n;
        if (lit && !blank2)
          an_n = 3'b011;
      end
      default: begin
        dig = s0_n;
        if (lit)
          an_n = 3'b110;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (dig),
    .seg (seg_dec)
  );

  assign seg_n = (an_n == AN_OFF) ? SEG_OFF : seg_dec;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= S_D0;
      cnt   <= '0;
      fcnt  <= '0;
      phase <= 1'b1;
      s0    <= 4'd0;
      s1    <= 4'd0;
      s2    <= 4'd0;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
    end else begin
      state <= st_n;
      cnt   <= cnt_n;
      fcnt  <= fc_n;
      phase <= ph_n;
      s0    <= s0_n;
      s1    <= s1_n;
      s2    <= s2_n;
      an    <= an_n;
      seg   <= seg_n;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan_3.sv
// Directed bench for bcd_display_scan_3 with small scan timing.
// Position in the frame is tracked by the bench from elapsed cycles.
module tb_bcd_display_scan_3;

  logic       clk = 1'b0;
  logic       areset_n = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] d0 = 4'd0;
  logic [3:0] d1 = 4'd0;
  logic [3:0] d2 = 4'd0;
  logic       maxed = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;

  int nchk = 0;
  int nfail = 0;
  int pos = 0;

  bcd_display_scan_3 #(
    .SCAN_DIV     (8),
    .BLANK        (2),
    .BLINK_FRAMES (2),
    .LZB          (1'b1)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .enable   (enable),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .maxed    (maxed),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic step1();
    @(negedge clk);
    pos++;
  endtask

  task automatic go_to(input int s, input int c);
    int guard;
    guard = 0;
    while ((pos % 24) != (s * 8 + c) && guard < 100) begin
      step1();
      guard++;
    end
  endtask

  task automatic test_reset();
    #1 areset_n = 1'b0;
    #2;
    nchk++;
    if ({an, seg} !== {3'b111, 7'h7F}) begin
      nfail++;
      $display("FAIL reset_state an=%b seg=%b exp 111/1111111", an, seg);
    end
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    @(negedge clk);
    areset_n = 1'b1;
    pos = 0;
    go_to(0, 4);
    #2 areset_n = 1'b0;
    #1;
    nchk++;
    if ({an, seg} !== {3'b111, 7'h7F}) begin
      nfail++;
      $display("FAIL async_reset an=%b seg=%b exp 111/1111111", an, seg);
    end
    @(negedge clk);
    areset_n = 1'b1;
    pos = 0;
    nchk++;
    if ({an, seg} !== {3'b111, 7'h7F}) begin
      nfail++;
      $display("FAIL reset_release an=%b seg=%b exp 111/1111111", an, seg);
    end
  endtask

  task automatic test_scan();
    logic [9:0] exp;
    for (int c = 0; c < 8; c++) begin
      go_to(0, c);
      exp = (c < 2) ? {3'b111, 7'b1111111} : {3'b110, 7'b0110000};
      nchk++;
      if ({an, seg} !== exp) begin
        nfail++;
        $display("FAIL scan_d0_c%0d got=%b exp=%b", c, {an, seg}, exp);
      end
    end
    go_to(1, 3);
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0100100}) begin
      nfail++;
      $display("FAIL scan_d1 got=%b exp=%b", {an, seg}, {3'b101, 7'b0100100});
    end
    go_to(2, 5);
    nchk++;
    if ({an, seg} !== {3'b011, 7'b1111001}) begin
      nfail++;
      $display("FAIL scan_d2 got=%b exp=%b", {an, seg}, {3'b011, 7'b1111001});
    end
  endtask

  task automatic test_lzb();
    int bad;
    bad = 0;
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
    go_to(0, 0);
    for (int i = 0; i < 24; i++) begin
      if (an[2] == 1'b0 || an[1] == 1'b0)
        bad++;
      if (i == 4) begin
        nchk++;
        if ({an, seg} !== {3'b110, 7'b1111000}) begin
          nfail++;
          $display("FAIL lzb_007_d0 got=%b exp=%b", {an, seg}, {3'b110, 7'b1111000});
        end
      end
      step1();
    end
    nchk++;
    if (bad !== 0) begin
      nfail++;
      $display("FAIL lzb_007_blank lit_cycles=%0d exp=0", bad);
    end
    d2 = 4'd0; d1 = 4'd5; d0 = 4'd0;
    go_to(0, 4);
    nchk++;
    if ({an, seg} !== {3'b110, 7'b1000000}) begin
      nfail++;
      $display("FAIL lzb_050_d0 got=%b exp=%b", {an, seg}, {3'b110, 7'b1000000});
    end
    go_to(1, 4);
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0010010}) begin
      nfail++;
      $display("FAIL lzb_050_d1 got=%b exp=%b", {an, seg}, {3'b101, 7'b0010010});
    end
    go_to(2, 4);
    nchk++;
    if ({an, seg} !== {3'b111, 7'b1111111}) begin
      nfail++;
      $display("FAIL lzb_050_d2 got=%b exp=%b", {an, seg}, {3'b111, 7'b1111111});
    end
  endtask

  task automatic test_snapshot();
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    go_to(0, 0);
    go_to(0, 4);
    d2 = 4'd9;
    go_to(1, 3);
    d0 = 4'd4;
    go_to(2, 4);
    nchk++;
    if ({an, seg} !== {3'b011, 7'b1111001}) begin
      nfail++;
      $display("FAIL snap_same_frame got=%b exp=%b", {an, seg}, {3'b011, 7'b1111001});
    end
    go_to(0, 4);
    nchk++;
    if ({an, seg} !== {3'b110, 7'b0011001}) begin
      nfail++;
      $display("FAIL snap_next_d0 got=%b exp=%b", {an, seg}, {3'b110, 7'b0011001});
    end
    go_to(2, 4);
    nchk++;
    if ({an, seg} !== {3'b011, 7'b0010000}) begin
      nfail++;
      $display("FAIL snap_next_d2 got=%b exp=%b", {an, seg}, {3'b011, 7'b0010000});
    end
  endtask

  task automatic test_blink();
    logic [5:0] pat;
    logic [9:0] exp;
    pat = 6'b110011;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    go_to(0, 0);
    maxed = 1'b1;
    for (int f = 0; f < 6; f++) begin
      go_to(0, 4);
      exp = pat[5 - f] ? {3'b110, 7'b0110000} : {3'b111, 7'b1111111};
      nchk++;
      if ({an, seg} !== exp) begin
        nfail++;
        $display("FAIL blink_frame%0d got=%b exp=%b", f + 1, {an, seg}, exp);
      end
      step1();
    end
    go_to(0, 4);
    nchk++;
    if ({an, seg} !== {3'b111, 7'b1111111}) begin
      nfail++;
      $display("FAIL blink_frame7 got=%b exp=%b", {an, seg}, {3'b111, 7'b1111111});
    end
    maxed = 1'b0;
    step1();
    nchk++;
    if ({an, seg} !== {3'b110, 7'b0110000}) begin
      nfail++;
      $display("FAIL blink_drop got=%b exp=%b", {an, seg}, {3'b110, 7'b0110000});
    end
    go_to(1, 4);
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0100100}) begin
      nfail++;
      $display("FAIL blink_drop_d1 got=%b exp=%b", {an, seg}, {3'b101, 7'b0100100});
    end
  endtask

  task automatic test_invalid();
    go_to(1, 5);
    d2 = 4'd0; d1 = 4'hA; d0 = 4'hC;
    go_to(0, 4);
    nchk++;
    if ({an, seg} !== {3'b110, 7'b0111111}) begin
      nfail++;
      $display("FAIL invalid_d0 got=%b exp=%b", {an, seg}, {3'b110, 7'b0111111});
    end
    go_to(1, 4);
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0111111}) begin
      nfail++;
      $display("FAIL invalid_d1 got=%b exp=%b", {an, seg}, {3'b101, 7'b0111111});
    end
    go_to(2, 4);
    nchk++;
    if ({an, seg} !== {3'b111, 7'b1111111}) begin
      nfail++;
      $display("FAIL invalid_d2 got=%b exp=%b", {an, seg}, {3'b111, 7'b1111111});
    end
  endtask

  task automatic test_enable();
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    go_to(0, 0);
    go_to(1, 3);
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0100100}) begin
      nfail++;
      $display("FAIL en_before got=%b exp=%b", {an, seg}, {3'b101, 7'b0100100});
    end
    enable = 1'b0;
    @(negedge clk);
    nchk++;
    if ({an, seg} !== {3'b111, 7'b1111111}) begin
      nfail++;
      $display("FAIL en_dark got=%b exp=%b", {an, seg}, {3'b111, 7'b1111111});
    end
    repeat (4) @(negedge clk);
    enable = 1'b1;
    step1();
    nchk++;
    if ({an, seg} !== {3'b101, 7'b0100100}) begin
      nfail++;
      $display("FAIL en_resume got=%b exp=%b", {an, seg}, {3'b101, 7'b0100100});
    end
    go_to(2, 1);
    nchk++;
    if ({an, seg} !== {3'b111, 7'b1111111}) begin
      nfail++;
      $display("FAIL en_align_blank got=%b exp=%b", {an, seg}, {3'b111, 7'b1111111});
    end
    go_to(2, 2);
    nchk++;
    if ({an, seg} !== {3'b011, 7'b1111001}) begin
      nfail++;
      $display("FAIL en_align_lit got=%b exp=%b", {an, seg}, {3'b011, 7'b1111001});
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_snapshot();
    test_blink();
    test_invalid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
